// File: rtl/regbus_arb_pkg.sv
// Shared types and round-robin helper for register-bus arbitration.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
// Contents: state_e (arbiter FSM states), rr_pick_t, rr_pick().
package regbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Returns the first set request found searching upward from last+1,
    // wrapping at n. Sized for up to 8 requesters; callers zero-extend.
    function automatic rr_pick_t rr_pick(input logic [7:0] req,
                                         input logic [2:0] last,
                                         input int         n);
        rr_pick_t   res;
        logic [2:0] cand;
        res = '0;
        for (int i = 1; i <= 8; i++) begin
            cand = 3'((int'(last) + i) % n);
            if (i <= n && !res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regbus_arbiter_rr.sv
// Combinational round-robin picker; the requester after last_i has priority.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to consume the pick.
// Ports: req_i request vector, last_i previous winner, idx_o winner, vld_o any request.
module rr_arbiter
    import regbus_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    logic [7:0] req_ext;
    logic [2:0] last_ext;
    rr_pick_t   pick;

    always_comb begin
        req_ext                 = '0;
        req_ext[NUM_REQ-1:0]    = req_i;
        last_ext                = '0;
        last_ext[IDX_W-1:0]     = last_i;
        pick                    = rr_pick(req_ext, last_ext, NUM_REQ);
    end

    assign idx_o = IDX_W'(pick.idx);
    assign vld_o = pick.found;

endmodule

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter sharing one strobe/ack register bus among NUM_REQ requesters.
// Latency: request to done >= 2 cycles; >= 3 cycles per transaction incl. arbitration.
// Backpressure: requesters hold req_valid until done; a missing ack ends in a timeout error.
// Ports: req_* requester side (flattened addr/wdata), rb_* register bus side,
//        busy/grant_idx status; clk, presetn async active-low reset.
module regbus_arbiter
    import regbus_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          presetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          req_err,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
    output logic [ADDR_WIDTH-1:0]         rb_waddr,
    output logic [ADDR_WIDTH-1:0]         rb_raddr,
    output logic [DATA_WIDTH-1:0]         rb_wdata,
    output logic                          rb_wstrobe,
    output logic                          rb_rstrobe,
    input  logic [DATA_WIDTH-1:0]         rb_rdata,
    input  logic                          rb_wack,
    input  logic                          rb_rack,
    input  logic                          rb_waddrerr,
    input  logic                          rb_raddrerr
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d, last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic                    wstb_q, wstb_d, rstb_q, rstb_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    pick_vld;
    logic [IDX_W-1:0]        pick_idx;
    logic                    ack, ack_err, complete, tmo;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req_i  (req_valid),
        .last_i (last_q),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

    // Only the ack matching the latched direction counts; the other is ignored.
    assign ack     = wr_q ? rb_wack     : rb_rack;
    assign ack_err = wr_q ? rb_waddrerr : rb_raddrerr;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        busy_d   = busy_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstb_d   = 1'b0;
        rstb_d   = 1'b0;
        done_d   = '0;
        err_d    = 1'b0;
        rdata_d  = '0;
        cnt_d    = cnt_q;
        complete = 1'b0;
        tmo      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    wr_d    = req_write[pick_idx];
                    addr_d  = req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    busy_d  = 1'b1;
                    wstb_d  = req_write[pick_idx];
                    rstb_d  = ~req_write[pick_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // An ack already in the strobe cycle completes; the done
                // pulse then lands in the following WAIT cycle.
                cnt_d    = '0;
                state_d  = WAIT;
                complete = ack;
            end
            WAIT: begin
                if (|done_q) begin
                    // Done cycle: the transaction is finished, drop back to arbitration.
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (ack) begin
                        complete = 1'b1;
                    end else if (TIMEOUT_CYCLES != 0 && cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        complete = 1'b1;
                        tmo      = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            done_d[grant_q] = 1'b1;
            err_d           = tmo | ack_err;
            rdata_d         = (tmo || wr_q) ? '0 : rb_rdata;
            last_d          = grant_q;
            busy_d          = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            busy_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wstb_q  <= 1'b0;
            rstb_q  <= 1'b0;
            done_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wstb_q  <= wstb_d;
            rstb_q  <= rstb_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_done   = done_q;
    assign req_rdata  = rdata_q;
    assign req_err    = err_q;
    assign busy       = busy_q;
    assign grant_idx  = grant_q;
    assign rb_waddr   = addr_q;
    assign rb_raddr   = addr_q;
    assign rb_wdata   = wdata_q;
    assign rb_wstrobe = wstb_q;
    assign rb_rstrobe = rstb_q;

endmodule

// File: doc/regbus_arbiter.md
Name: regbus_arbiter

Overview:
- Shares one generic register bus (strobe/ack protocol, separate read/write strobes, ack and address-error per direction) between NUM_REQ requesters, e.g. APB bridge plus debug master.
- Round-robin arbitration, one outstanding transaction at a time.
- Per-transaction timeout so a missing ack never hangs a requester.
- Sits between the bus-protocol front ends and the register block.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 8, register address width.
- DATA_WIDTH, 32, register data width.
- TIMEOUT_CYCLES, 64, WAIT-state cycles before forced error completion; 0 disables the timeout.

Ports:
- clk  in  1  clock
- presetn  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request; held until its done pulse
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; slice i belongs to requester i
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- req_rdata  out  DATA_WIDTH  read data; valid while any req_done is high
- req_err  out  1  error flag; valid while any req_done is high
- busy  out  1  transaction in progress
- grant_idx  out  $clog2(NUM_REQ)  index of the current/last granted requester
- rb_waddr, rb_raddr  out  ADDR_WIDTH  bus addresses, both driven from latched address
- rb_wdata  out  DATA_WIDTH  bus write data
- rb_wstrobe, rb_rstrobe  out  1  one-cycle strobes, registered
- rb_rdata  in  DATA_WIDTH  bus read data
- rb_wack, rb_rack  in  1  acknowledges
- rb_waddrerr, rb_raddrerr  in  1  address errors, sampled with the matching ack

Behaviour:
- Reset (async, presetn low), applied at any time including mid-transaction:
  - State IDLE; all outputs 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
  - Timeout counter 0.
  - Any in-flight transaction is abandoned with no done pulse.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid, pick the first set bit searching from last+1 with wrap-around.
  - Latch that requester's write/addr/wdata into internal registers; set grant_idx and busy=1; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly one cycle):
  - rb_wstrobe = latched write, rb_rstrobe = !latched write; the two are never high together.
  - Always go to WAIT. An ack seen in ISSUE is accepted and completes the transaction.
- WAIT:
  - Completion on the direction-matching ack: rb_wack for writes, rb_rack for reads.
  - Opposite-direction acks are ignored.
- Completion (registered, the cycle after the ack is sampled):
  - req_done[grant_idx] = 1 for one cycle.
  - req_err = matching addrerr.
  - req_rdata = rb_rdata for reads, 0 for writes.
  - last = grant_idx; busy = 0; go to IDLE.
- Timeout:
  - Counter clears in ISSUE and increments every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without an ack, complete with req_err=1, req_rdata=0.
  - An ack arriving in the same cycle the counter reaches TIMEOUT_CYCLES wins: normal completion.
- Latency: req_valid sampled high in cycle 0, strobe in cycle 1, ack in cycle 1 → done in cycle 2. Minimum 2 cycles request-to-done; minimum 3 cycles per transaction including the IDLE arbitration cycle.
- Requester rules:
  - A requester dropping req_valid mid-transaction has no effect; the transaction completes and done still pulses.
  - The requester may reassert in the cycle after done; it is then lowest priority.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NUM_REQ-1,0.
- Addresses/data sampled only in IDLE; changes to req_addr/req_wdata after grant are ignored.
- rb_waddr/rb_raddr/rb_wdata hold their latched values until the next grant.

Decomposition:
- Package regbus_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT).
  - Localparam-free helper function rr_pick(req vector, last index) returning winner index plus found flag.
- Sub-module rr_arbiter: combinational round-robin picker (inputs req vector and last pointer; outputs winner index and valid). It is reused by other arbiters in the codebase.
- The top module holds the FSM, latches, timeout counter and completion logic.

Test Plan:
- Single read from requester 0 (addr 0x10), rack in the strobe cycle with rb_rdata=0xDEADBEEF → req_done[0] one cycle later, req_rdata=0xDEADBEEF, req_err=0; rb_rstrobe high exactly 1 cycle, rb_wstrobe never high.
- Requesters 0 and 1 request writes simultaneously and continuously, ack after 2 cycles → grant order 0,1,0,1; each done pulses once per transaction; no overlapping strobes.
- Write to 0xFF with rb_wack and rb_waddrerr both high → req_err=1; a spurious rb_rack during the WAIT state is ignored (no early done).
- TIMEOUT_CYCLES=4, no ack → done exactly 4 WAIT cycles after the strobe, req_err=1, req_rdata=0. Repeat with rack on the 4th WAIT cycle → normal completion, req_err=0.
- presetn asserted during WAIT → all outputs 0 immediately, no req_done pulse; after release, requester 0 is granted first even if requester 1 was in flight.
- Requester deasserts req_valid and changes req_addr after grant → bus address remains the latched value and req_done still pulses.
